// File: rtl/rr_chan_rec_packer.sv
// -----------------------------------------------------------------------------
// rr_chan_rec_packer
//
// Recording-bus producer for record/replay. Snoops N_CH valid/ready channels.
// In every cycle where at least one channel fires, it packs one entry: a
// bitmask of the fired channels plus all channel payloads, with the lanes of
// non-fired channels forced to zero. Entries go into a DEPTH-entry
// first-word-fall-through FIFO that drains over a valid/ready recording bus.
// A registered stall output asks the wrapper to stop the snooped channels
// before the FIFO can fill.
//
// Optional feature (macro RR_REC_PACKER_TIMESTAMP_EN):
//   A free-running 32-bit cycle counter is sampled in the push cycle, stored
//   with each entry and presented on rec_ts with the head entry.
//
// Ports:
//   clk        single clock
//   rst        asynchronous, active-high reset
//   in_valid   [N_CH]       snooped valid per channel
//   in_ready   [N_CH]       snooped ready per channel
//   in_data    [N_CH*CH_W]  snooped payload, channel i at [i*CH_W +: CH_W]
//   rec_valid  head entry available (count != 0)
//   rec_ready  consumer accepts the head entry
//   rec_hdr    [N_CH]       fired-channel bitmask of the head entry
//   rec_data   [N_CH*CH_W]  payload of the head entry
//   rec_ts     [32]         push-cycle timestamp of the head (macro only)
//   stall      registered request to deassert ready on all snooped channels
//   count      [clog2(DEPTH+1)] FIFO occupancy
//   overflow   sticky flag: an entry was dropped (cleared only by rst)
// -----------------------------------------------------------------------------
module rr_chan_rec_packer #(
   parameter int N_CH           = 5,
   parameter int CH_W           = 64,
   parameter int DEPTH          = 16,
   parameter int ALMFULL_MARGIN = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_CH-1:0]            in_valid,
   input  logic [N_CH-1:0]            in_ready,
   input  logic [N_CH*CH_W-1:0]       in_data,
   output logic                       rec_valid,
   input  logic                       rec_ready,
   output logic [N_CH-1:0]            rec_hdr,
   output logic [N_CH*CH_W-1:0]       rec_data,
`ifdef RR_REC_PACKER_TIMESTAMP_EN
   output logic [31:0]                rec_ts,
`endif
   output logic                       stall,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int DW = N_CH * CH_W;
`ifdef RR_REC_PACKER_TIMESTAMP_EN
   localparam int EW = 32 + N_CH + DW;
`else
   localparam int EW = N_CH + DW;
`endif

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] STALL_TH_C = CW'(DEPTH - ALMFULL_MARGIN);

   // ---------------------------------------------------------------- capture
   logic [N_CH-1:0] fire;
   logic            push;
   logic [DW-1:0]   data_masked;
   logic [EW-1:0]   entry_in;

   assign fire = in_valid & in_ready;
   assign push = |fire;

   // Lanes of channels that did not fire are zeroed so the consumer never
   // sees stale payload from an idle bus.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      assign data_masked[gi*CH_W +: CH_W] = fire[gi] ? in_data[gi*CH_W +: CH_W] : '0;
   end

   // ------------------------------------------------------------- registers
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic          stall_q,  stall_d;
   logic          overflow_q, overflow_d;

`ifdef RR_REC_PACKER_TIMESTAMP_EN
   logic [31:0] ts_q, ts_d;
   assign entry_in = {ts_q, fire, data_masked};
`else
   assign entry_in = {fire, data_masked};
`endif

   // ------------------------------------------------------------ next state
   logic pop;
   logic full;
   logic wr_en;
   logic drop;

   always_comb begin
      pop        = (count_q != '0) & rec_ready;
      full       = (count_q == DEPTH_C);
      // When full, a same-cycle pop frees the slot the write lands in
      // (wr_ptr == rd_ptr), so the push can still be accepted.
      wr_en      = push & (~full | pop);
      drop       = push & full & ~pop;

      count_d    = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      wr_ptr_d   = wr_ptr_q + AW'(wr_en);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      overflow_d = overflow_q | drop;
      stall_d    = (count_d >= STALL_TH_C);
`ifdef RR_REC_PACKER_TIMESTAMP_EN
      ts_d       = ts_q + 32'd1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
`ifdef RR_REC_PACKER_TIMESTAMP_EN
         ts_q       <= '0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
`ifdef RR_REC_PACKER_TIMESTAMP_EN
         ts_q       <= ts_d;
`endif
      end
   end

   // ---------------------------------------------------------------- storage
   // Storage is not reset; validity is governed entirely by count_q, which
   // is why a reset flushes every entry at once.
   logic [EW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= entry_in;
      end
   end

   // -------------------------------------------------------------- head out
   // Fall-through read; gating on occupancy keeps the head at zero when the
   // FIFO is empty, including immediately after an asynchronous reset.
   logic [EW-1:0] head;

   assign head      = mem[rd_ptr_q];
   assign rec_valid = (count_q != '0);
   assign rec_hdr   = rec_valid ? head[DW +: N_CH] : '0;
   assign rec_data  = rec_valid ? head[DW-1:0]     : '0;
`ifdef RR_REC_PACKER_TIMESTAMP_EN
   assign rec_ts    = rec_valid ? head[EW-1 -: 32] : '0;
`endif
   assign stall     = stall_q;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_rr_chan_rec_packer.sv
// -----------------------------------------------------------------------------
// tb_rr_chan_rec_packer
//
// Drives rr_chan_rec_packer with directed and randomized channel traffic and
// compares every output after every clock edge against a queue-based model
// of the recording FIFO (entries, occupancy, stall, sticky overflow).
// -----------------------------------------------------------------------------
module tb_rr_chan_rec_packer;

   localparam int N_CH   = 5;
   localparam int CH_W   = 64;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 4;
   localparam int DW     = N_CH * CH_W;
   localparam int CW     = $clog2(DEPTH+1);

   logic                clk = 1'b0;
   logic                rst;
   logic [N_CH-1:0]     in_valid;
   logic [N_CH-1:0]     in_ready;
   logic [DW-1:0]       in_data;
   logic                rec_valid;
   logic                rec_ready;
   logic [N_CH-1:0]     rec_hdr;
   logic [DW-1:0]       rec_data;
   logic                stall;
   logic [CW-1:0]       count;
   logic                overflow;
`ifdef RR_REC_PACKER_TIMESTAMP_EN
   logic [31:0]         rec_ts;
`endif

   rr_chan_rec_packer #(
      .N_CH(N_CH), .CH_W(CH_W), .DEPTH(DEPTH), .ALMFULL_MARGIN(MARGIN)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_hdr(rec_hdr), .rec_data(rec_data),
`ifdef RR_REC_PACKER_TIMESTAMP_EN
      .rec_ts(rec_ts),
`endif
      .stall(stall), .count(count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------------ reference
   typedef struct {
      logic [N_CH-1:0] hdr;
      logic [DW-1:0]   data;
      logic [31:0]     ts;
   } ent_t;

   ent_t        q[$];
   bit          ovf_m;
   bit          stall_m;
   logic [31:0] ts_m;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      chk("rec_valid", DW'(rec_valid), DW'(q.size() != 0));
      chk("count",     DW'(count),     DW'(q.size()));
      chk("rec_hdr",   DW'(rec_hdr),   (q.size() != 0) ? DW'(q[0].hdr) : '0);
      chk("rec_data",  rec_data,       (q.size() != 0) ? q[0].data : '0);
      chk("stall",     DW'(stall),     DW'(stall_m));
      chk("overflow",  DW'(overflow),  DW'(ovf_m));
`ifdef RR_REC_PACKER_TIMESTAMP_EN
      chk("rec_ts",    DW'(rec_ts),    (q.size() != 0) ? DW'(q[0].ts) : '0);
`endif
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   // One clock: apply current inputs, advance the model by the FIFO rules,
   // then compare outputs 1 time unit after the edge.
   task automatic step();
      logic [N_CH-1:0] f;
      int              pre;
      bit              pop_m;
      ent_t            e;
      f = in_valid & in_ready;
      e.hdr  = f;
      e.data = '0;
      for (int c = 0; c < N_CH; c++)
         if (f[c]) e.data[c*CH_W +: CH_W] = in_data[c*CH_W +: CH_W];
      e.ts = ts_m;
      @(posedge clk);
      pre   = q.size();
      pop_m = (pre != 0) && rec_ready;
      if (pop_m) void'(q.pop_front());
      if (f != '0) begin
         if (pre < DEPTH || pop_m) q.push_back(e);
         else                      ovf_m = 1'b1;
      end
      stall_m = (q.size() >= DEPTH - MARGIN);
      ts_m    = ts_m + 32'd1;
      #1;
      check_outputs();
   endtask

   task automatic model_reset();
      q.delete();
      ovf_m   = 1'b0;
      stall_m = 1'b0;
      ts_m    = '0;
   endtask

   task automatic idle();
      in_valid = '0;
      in_ready = '0;
      in_data  = rand_data();
   endtask

   // Random channel traffic; the wrapper honours stall immediately.
   task automatic rand_cycles(input int n, input int ready_pct);
      for (int k = 0; k < n; k++) begin
         in_valid  = N_CH'($urandom);
         in_ready  = N_CH'($urandom) & {N_CH{~stall}};
         in_data   = rand_data();
         rec_ready = ($urandom_range(99) < ready_pct);
         step();
      end
   endtask

   initial begin
      rst       = 1'b1;
      rec_ready = 1'b0;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      // Single fire on channel 2, garbage on other lanes must be masked.
      rec_ready = 1'b1;
      in_valid  = 5'b00100;
      in_ready  = '1;
      in_data   = rand_data();
      in_data[2*CH_W +: CH_W] = 64'hDEADBEEF;
      step();
      chk("single_hdr", DW'(rec_hdr), DW'(5'b00100));
      idle();
      step();

      // Two channels in the same cycle form exactly one entry.
      in_valid = 5'b10001;
      in_ready = 5'b10001;
      in_data  = rand_data();
      in_data[0*CH_W +: CH_W] = 64'h11;
      in_data[4*CH_W +: CH_W] = 64'h44;
      step();
      chk("multi_hdr", DW'(rec_hdr), DW'(5'b10001));
      idle();
      step();

      // Backpressure: stall must build up and drain with rec_ready released.
      rec_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         in_valid = 5'b00001;
         in_ready = {N_CH{~stall}};
         in_data  = rand_data();
         step();
      end
      idle();
      rec_ready = 1'b1;
      repeat (16) step();

      rand_cycles(200, 25);
      rand_cycles(200, 60);
      idle();
      rec_ready = 1'b1;
      repeat (18) step();

      // Fill to DEPTH ignoring stall, then push+pop at full, then a drop.
      rec_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         in_valid = N_CH'($urandom) | 5'b00001;
         in_ready = '1;
         in_data  = rand_data();
         step();
      end
      rec_ready = 1'b1;
      in_data   = rand_data();
      step();
      rec_ready = 1'b0;
      in_data   = rand_data();
      step();
      idle();
      repeat (3) step();
      rec_ready = 1'b1;
      repeat (18) step();

      // Reset between edges with 7 entries queued.
      rec_ready = 1'b0;
      for (int k = 0; k < 7; k++) begin
         in_valid = 5'b01010;
         in_ready = '1;
         in_data  = rand_data();
         step();
      end
      idle();
      #2 rst = 1'b1;
      model_reset();
      #1;
      check_outputs();
      #2 rst = 1'b0;
      rec_ready = 1'b1;
      repeat (3) step();

      rand_cycles(100, 50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
